// File: rtl/cfg_chain_loader.sv
// Configuration-chain loader: serialises bitstream words into the row scan chain,
// recirculates the chain once for readback, and compares CRC-16 of both streams.
module cfg_chain_loader #(
    parameter int N_ROWS   = 8,
    parameter int ROW_BITS = 64,
    parameter int WORD_W   = 8
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              chain_out,
    output logic              chain_en,
    input  logic              chain_in,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CHAIN_LEN = N_ROWS * ROW_BITS;
    localparam int CNT_W     = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
    localparam int REM_W     = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(WORD_W);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [15:0]      CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        CHECK
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [REM_W-1:0]  rem;
    logic [CNT_W-1:0]  bit_cnt;
    logic [15:0]       load_crc;
    logic [15:0]       rb_crc;
    logic              shift_now;

    // CRC-16-CCITT, MSB-first register, one bit per call.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign shift_now  = (state == LOAD) && (rem != '0);
    // Accepting on the last serialised bit keeps a continuous stream bubble-free.
    assign word_ready = (state == LOAD) &&
                        ((rem == '0) || ((rem == REM_ONE) && (bit_cnt != LAST_BIT)));
    assign chain_en   = shift_now || (state == VERIFY);
    assign busy       = (state != IDLE);

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        chain_out = 1'b0;
        if (shift_now)
            chain_out = shreg[0];
        else if (state == VERIFY)
            chain_out = chain_in;
    end

    // NOTE: all state here uses non-blocking assignments; where two branches assign
    // the same register in one cycle, the later one in program order takes effect.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            rem      <= '0;
            bit_cnt  <= '0;
            load_crc <= CRC_INIT;
            rb_crc   <= CRC_INIT;
            done     <= 1'b0;
            error    <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            rem     <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        load_crc <= CRC_INIT;
                        rb_crc   <= CRC_INIT;
                        bit_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (shift_now) begin
                        shreg    <= shreg >> 1;
                        rem      <= rem - REM_ONE;
                        load_crc <= crc_step(load_crc, shreg[0]);
                        if (bit_cnt == LAST_BIT) begin
                            state   <= VERIFY;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    // A new word overrides the shift update of shreg/rem on the same edge.
                    if (word_valid && word_ready) begin
                        shreg <= word_data;
                        rem   <= REM_FULL;
                    end
                end
                VERIFY: begin
                    rb_crc <= crc_step(rb_crc, chain_in);
                    if (bit_cnt == LAST_BIT) begin
                        state   <= CHECK;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (rb_crc == load_crc)
                        done <= 1'b1;
                    else
                        error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
